// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory controller and its arbiter:
// arbiter state encoding, SPI command bytes and transfer lengths.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D_WAIT,
    ST_F_STREAM,
    ST_GAP
  } arb_state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [5:0] LEN_B = 6'd8;
  localparam logic [5:0] LEN_H = 6'd16;
  localparam logic [5:0] LEN_W = 6'd32;

  // RISC-V style length decode on the first halfword of a raw serial word
  function automatic logic is_compressed(input logic [31:0] w);
    return w[25:24] != 2'b11;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter.sv
// Shares one spi_mem between instruction fetch (streamed, one-word prefetch
// buffer) and data load/store (single transactions with a chip-select gap).
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned CS_GAP      = 2,
  parameter bit          FETCH_FLASH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_flash,
  input  logic [23:0] d_addr,
  input  logic [5:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_start,
  output logic        mem_stop,
  output logic        mem_we,
  output logic        mem_is_instr,
  output logic        mem_use_flash,
  output logic [23:0] mem_addr,
  output logic [5:0]  mem_len,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int unsigned GW = (CS_GAP < 2) ? 1 : $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP);

  arb_state_t    state, state_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [23:0]   exp_addr, exp_addr_n;
  logic          buf_valid, buf_valid_n;
  logic [23:0]   buf_addr, buf_addr_n;
  logic [31:0]   buf_data, buf_data_n;
  logic          stop_pend;

  logic        if_ack_n, d_ack_n, mem_start_n, mem_stop_n;
  logic        mem_we_n, mem_is_instr_n, mem_use_flash_n;
  logic [31:0] if_rdata_n, d_rdata_n, mem_wdata_n;
  logic [23:0] mem_addr_n;
  logic [5:0]  mem_len_n;

  logic        if_req_v, d_req_v, buf_hit;
  logic [23:0] next_addr;

  // A request is ignored in the cycle its ack is visible; the requester drops it then.
  assign if_req_v  = if_req && !if_ack;
  assign d_req_v   = d_req && !d_ack;
  assign buf_hit   = buf_valid && (if_addr == buf_addr);
  assign next_addr = exp_addr + (is_compressed(mem_rdata) ? 24'd2 : 24'd4);

  always_comb begin
    state_n         = state;
    gap_n           = (gap_cnt != '0) ? gap_cnt - 1'b1 : '0;
    exp_addr_n      = exp_addr;
    buf_valid_n     = buf_valid;
    buf_addr_n      = buf_addr;
    buf_data_n      = buf_data;
    if_ack_n        = 1'b0;
    d_ack_n         = 1'b0;
    mem_start_n     = 1'b0;
    mem_stop_n      = 1'b0;
    if_rdata_n      = if_rdata;
    d_rdata_n       = d_rdata;
    mem_we_n        = mem_we;
    mem_is_instr_n  = mem_is_instr;
    mem_use_flash_n = mem_use_flash;
    mem_addr_n      = mem_addr;
    mem_len_n       = mem_len;
    mem_wdata_n     = mem_wdata;

    if (stop_pend) begin
      mem_stop_n = 1'b1;
      gap_n      = GAP_LOAD;
      state_n    = ST_GAP;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (d_req_v) begin
            if (gap_cnt == '0) begin
              mem_start_n     = 1'b1;
              mem_addr_n      = d_addr;
              mem_len_n       = d_len;
              mem_we_n        = d_we;
              mem_is_instr_n  = 1'b0;
              mem_use_flash_n = d_flash;
              mem_wdata_n     = d_wdata;
              if (d_we || d_flash) buf_valid_n = 1'b0;
              state_n         = ST_D_WAIT;
            end
          end else if (if_req_v) begin
            if (buf_hit) begin
              if_ack_n    = 1'b1;
              if_rdata_n  = buf_data;
              buf_valid_n = 1'b0;
            end else if (gap_cnt == '0) begin
              mem_start_n     = 1'b1;
              mem_addr_n      = if_addr;
              mem_len_n       = LEN_W;
              mem_we_n        = 1'b0;
              mem_is_instr_n  = 1'b1;
              mem_use_flash_n = FETCH_FLASH;
              mem_wdata_n     = '0;
              exp_addr_n      = if_addr;
              buf_valid_n     = 1'b0;
              state_n         = ST_F_STREAM;
            end
          end
        end

        ST_D_WAIT: begin
          if (mem_done) begin
            d_ack_n   = 1'b1;
            d_rdata_n = mem_we ? '0 : mem_rdata;
            gap_n     = GAP_LOAD;
            state_n   = ST_IDLE;
          end
        end

        ST_F_STREAM: begin
          if (mem_done) begin
            exp_addr_n = next_addr;
            if (if_req_v && (if_addr == exp_addr)) begin
              if_ack_n   = 1'b1;
              if_rdata_n = mem_rdata;
            end else if (if_req_v && buf_hit) begin
              if_ack_n   = 1'b1;
              if_rdata_n = buf_data;
              buf_addr_n = exp_addr;
              buf_data_n = mem_rdata;
            end else if (!buf_valid) begin
              buf_valid_n = 1'b1;
              buf_addr_n  = exp_addr;
              buf_data_n  = mem_rdata;
            end else begin
              // Overflow: the new word is dropped, the older buffered word stays usable
              mem_stop_n = 1'b1;
              gap_n      = GAP_LOAD;
              state_n    = ST_GAP;
            end
          end else if (if_req_v && buf_hit) begin
            if_ack_n    = 1'b1;
            if_rdata_n  = buf_data;
            buf_valid_n = 1'b0;
          end else if (if_req_v && (if_addr == exp_addr)) begin
            state_n = ST_F_STREAM;
          end else if (if_req_v || d_req_v) begin
            mem_stop_n = 1'b1;
            gap_n      = GAP_LOAD;
            state_n    = ST_GAP;
            if (if_req_v) buf_valid_n = 1'b0;
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) state_n = ST_IDLE;
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Remember an open transaction across reset so spi_mem gets closed afterwards
      stop_pend     <= stop_pend || (state == ST_D_WAIT) || (state == ST_F_STREAM);
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      exp_addr      <= '0;
      buf_valid     <= 1'b0;
      buf_addr      <= '0;
      buf_data      <= '0;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      mem_start     <= 1'b0;
      mem_stop      <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      mem_we        <= 1'b0;
      mem_is_instr  <= 1'b0;
      mem_use_flash <= 1'b0;
      mem_addr      <= '0;
      mem_len       <= '0;
      mem_wdata     <= '0;
    end else begin
      stop_pend     <= 1'b0;
      state         <= state_n;
      gap_cnt       <= gap_n;
      exp_addr      <= exp_addr_n;
      buf_valid     <= buf_valid_n;
      buf_addr      <= buf_addr_n;
      buf_data      <= buf_data_n;
      if_ack        <= if_ack_n;
      d_ack         <= d_ack_n;
      mem_start     <= mem_start_n;
      mem_stop      <= mem_stop_n;
      if_rdata      <= if_rdata_n;
      d_rdata       <= d_rdata_n;
      mem_we        <= mem_we_n;
      mem_is_instr  <= mem_is_instr_n;
      mem_use_flash <= mem_use_flash_n;
      mem_addr      <= mem_addr_n;
      mem_len       <= mem_len_n;
      mem_wdata     <= mem_wdata_n;
    end
  end

endmodule
